// File: rtl/reg_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready back-pressure and flush.
// Define REG_PIPE_QBAR_EN to add the complemented output port q_bar.
module reg_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready
`ifdef REG_PIPE_QBAR_EN
  ,
  output logic [WIDTH-1:0] q_bar
`endif
);

  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            rdy;
  logic [DEPTH-1:0]            up_vld;
  logic [DEPTH-1:0][WIDTH-1:0] up_data;
  logic                        hole;

  // A stage is ready when the output drains or any stage at or below it is empty.
  // This is the unrolled form of rdy[i] = ~v[i] | rdy[i+1].
  always_comb begin
    hole = 1'b0;
    rdy  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hole   = hole | ~vld_q[i];
      rdy[i] = hole | out_ready;
    end
  end

  always_comb begin
    up_vld     = '0;
    up_data    = '0;
    up_vld[0]  = in_valid;
    up_data[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      up_vld[i]  = vld_q[i-1];
      up_data[i] = data_q[i-1];
    end
  end

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i]) vld_d[i] = up_vld[i];
      // Bubbles and flushed inputs leave the data register untouched.
      if (rdy[i] && up_vld[i] && !flush) data_d[i] = up_data[i];
    end
    if (flush) vld_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign in_ready  = rdy[0];
  assign q         = data_q[DEPTH-1];
  assign out_valid = vld_q[DEPTH-1];

`ifdef REG_PIPE_QBAR_EN
  assign q_bar = ~q;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Directed self-checking bench for reg_pipe (WIDTH=8, DEPTH=4).
module tb_reg_pipe;
  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic [7:0] d;
  logic       in_ready, out_valid;
  logic [7:0] q;
`ifdef REG_PIPE_QBAR_EN
  logic [7:0] q_bar;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  reg_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .d         (d),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef REG_PIPE_QBAR_EN
    ,
    .q_bar     (q_bar)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    d        = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  logic [7:0] bp_w [5];
  logic [7:0] st_w [3];

  initial begin
    bp_w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    st_w = '{8'hA5, 8'h3C, 8'hFF};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_q", {24'd0, q}, 32'h00);
`ifdef REG_PIPE_QBAR_EN
    chk("rst_q_bar", {24'd0, q_bar}, 32'hFF);
`endif
    chk("rst_in_ready", {31'd0, in_ready}, 1);

    // Streaming: three back-to-back words, first one visible after 4 edges
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d = st_w[k]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("stream_lat_empty", {31'd0, out_valid}, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stream_vld", {31'd0, out_valid}, 1);
      chk("stream_q", {24'd0, q}, {24'd0, st_w[k]});
    end
    tick();
    chk("stream_done", {31'd0, out_valid}, 0);

    // Back-pressure: fifth word blocked until the consumer frees a slot
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      d = bp_w[k]; in_valid = 1'b1;
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, (k < 4) ? 1 : 0);
      tick();
    end
    chk("bp_full", {31'd0, in_ready}, 0);
    chk("bp_head", {24'd0, q}, 32'h11);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      chk("bp_vld", {31'd0, out_valid}, 1);
      chk("bp_q", {24'd0, q}, {24'd0, bp_w[k]});
      tick();
    end
    chk("bp_drained", {31'd0, out_valid}, 0);

    // Simultaneous pop and push while full
    out_ready = 1'b0;
    push(8'h61); push(8'h62); push(8'h63); push(8'h64);
    chk("sim_full", {31'd0, in_ready}, 0);
    d = 8'h65; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("sim_ready", {31'd0, in_ready}, 1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("sim_still_full", {31'd0, in_ready}, 0);
    chk("sim_head", {24'd0, q}, 32'h62);
    out_ready = 1'b1;
    tick(); chk("sim_q63", {24'd0, q}, 32'h63);
    tick(); chk("sim_q64", {24'd0, q}, 32'h64);
    tick(); chk("sim_q65", {24'd0, q}, 32'h65);
    tick(); chk("sim_empty", {31'd0, out_valid}, 0);

    // Bubble collapse under a stalled output
    out_ready = 1'b0;
    push(8'h71); tick(); tick(); push(8'h72);
    tick(); tick();
    chk("bub_head_vld", {31'd0, out_valid}, 1);
    chk("bub_head_q", {24'd0, q}, 32'h71);
    chk("bub_not_full", {31'd0, in_ready}, 1);
    out_ready = 1'b1;
    tick();
    chk("bub_adj_vld", {31'd0, out_valid}, 1);
    chk("bub_adj_q", {24'd0, q}, 32'h72);
    tick();
    chk("bub_empty", {31'd0, out_valid}, 0);

    // Flush with an input offered in the same cycle
    out_ready = 1'b0;
    push(8'h81); push(8'h82); push(8'h83);
    d = 8'h84; in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("fl_pre_ready", {31'd0, in_ready}, 1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", {31'd0, out_valid}, 0);
    chk("fl_in_ready", {31'd0, in_ready}, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("fl_nothing", {31'd0, out_valid}, 0);
    end

    // Reset mid-stream; last stage still holds a stale 72 beforehand
    out_ready = 1'b0;
    push(8'h91); push(8'h92); push(8'h93);
    d = 8'h94; in_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rs_out_valid", {31'd0, out_valid}, 0);
    chk("rs_q", {24'd0, q}, 32'h00);
`ifdef REG_PIPE_QBAR_EN
    chk("rs_q_bar", {24'd0, q_bar}, 32'hFF);
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rs_nothing", {31'd0, out_valid}, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
